// File: rtl/sargantana_icache_flush_ctrl.sv
// Icache flush sequencer: blocks lookups, drains the outstanding miss, then sweeps every set with an invalidate write.
// Optional build macro ICACHE_FLUSH_STATS_EN adds the flush_count_o / flush_cycles_o statistics counters.
module sargantana_icache_flush_ctrl #(
  parameter  int unsigned ICACHE_DEPTH = 64,
  localparam int unsigned ADDR_WIDTH   = $clog2(ICACHE_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_req_i,
  input  logic                  miss_inflight_i,
  input  logic                  inval_ready_i,
  output logic                  inval_valid_o,
  output logic [ADDR_WIDTH-1:0] inval_addr_o,
  output logic                  lookup_block_o,
  output logic                  busy_o,
`ifdef ICACHE_FLUSH_STATS_EN
  output logic                  flush_ack_o,
  output logic [31:0]           flush_count_o,
  output logic [31:0]           flush_cycles_o
`else
  output logic                  flush_ack_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWEEP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] counter_q, counter_d;
  logic                  pending_q, pending_d;
  logic                  inval_valid_d, lookup_block_d, busy_d, flush_ack_d;
  logic                  transfer;

  assign transfer     = inval_valid_o & inval_ready_i;
  assign inval_addr_o = counter_q;

  // State, sweep index, pending request and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      counter_q      <= '0;
      pending_q      <= 1'b0;
      inval_valid_o  <= 1'b0;
      lookup_block_o <= 1'b0;
      busy_o         <= 1'b0;
      flush_ack_o    <= 1'b0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      pending_q      <= pending_d;
      inval_valid_o  <= inval_valid_d;
      lookup_block_o <= lookup_block_d;
      busy_o         <= busy_d;
      flush_ack_o    <= flush_ack_d;
    end
  end

  // Next state; outputs are decoded from the next state so they line up with it after the edge
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    pending_d = pending_q;

    unique case (state_q)
      IDLE: begin
        if (flush_req_i) state_d = DRAIN;
      end
      DRAIN: begin
        // Requests here are covered by the sweep that has not started yet
        if (!miss_inflight_i) state_d = SWEEP;
      end
      SWEEP: begin
        if (flush_req_i) pending_d = 1'b1;
        if (transfer) begin
          counter_d = counter_q + ADDR_WIDTH'(1);
          if (&counter_q) state_d = DONE;
        end
      end
      DONE: begin
        state_d   = (pending_q || flush_req_i) ? DRAIN : IDLE;
        pending_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    inval_valid_d  = (state_d == SWEEP);
    lookup_block_d = (state_d != IDLE);
    busy_d         = (state_d != IDLE);
    flush_ack_d    = (state_d == DONE);
  end

`ifdef ICACHE_FLUSH_STATS_EN
  // Saturating flush statistics
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flush_count_o  <= '0;
      flush_cycles_o <= '0;
    end else begin
      if (flush_ack_o && (flush_count_o != 32'hFFFF_FFFF))
        flush_count_o <= flush_count_o + 32'd1;
      if (busy_o && (flush_cycles_o != 32'hFFFF_FFFF))
        flush_cycles_o <= flush_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sargantana_icache_flush_ctrl.sv
// Scoreboard bench for sargantana_icache_flush_ctrl: a 64-set instance plus a 2-set instance.
module tb_sargantana_icache_flush_ctrl;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned AW     = 6;
  localparam int unsigned DEPTH2 = 2;
  localparam int unsigned AW2    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush_req, miss_inflight, inval_ready;
  logic          inval_valid, lookup_block, busy, flush_ack;
  logic [AW-1:0] inval_addr;

  logic           req2, miss2, ready2;
  logic           valid2, block2, busy2, ack2;
  logic [AW2-1:0] addr2;

`ifdef ICACHE_FLUSH_STATS_EN
  logic [31:0] count1, cycles1, count2, cycles2;
`endif

  sargantana_icache_flush_ctrl #(.ICACHE_DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_req_i    (flush_req),
    .miss_inflight_i(miss_inflight),
    .inval_ready_i  (inval_ready),
    .inval_valid_o  (inval_valid),
    .inval_addr_o   (inval_addr),
    .lookup_block_o (lookup_block),
    .busy_o         (busy),
`ifdef ICACHE_FLUSH_STATS_EN
    .flush_ack_o    (flush_ack),
    .flush_count_o  (count1),
    .flush_cycles_o (cycles1)
`else
    .flush_ack_o    (flush_ack)
`endif
  );

  sargantana_icache_flush_ctrl #(.ICACHE_DEPTH(DEPTH2)) dut2 (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_req_i    (req2),
    .miss_inflight_i(miss2),
    .inval_ready_i  (ready2),
    .inval_valid_o  (valid2),
    .inval_addr_o   (addr2),
    .lookup_block_o (block2),
    .busy_o         (busy2),
`ifdef ICACHE_FLUSH_STATS_EN
    .flush_ack_o    (ack2),
    .flush_count_o  (count2),
    .flush_cycles_o (cycles2)
`else
    .flush_ack_o    (ack2)
`endif
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  // One clock, then settle past the edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input int depth);
    for (int a = 0; a < depth; a++) exp_q.push_back(a);
  endtask

  task automatic test_reset;
    rst = 1'b1; flush_req = 1'b1; miss_inflight = 1'b0; inval_ready = 1'b1;
    req2 = 1'b1; miss2 = 1'b0; ready2 = 1'b1;
    tick; tick;
    checks++;
    if ({inval_valid, lookup_block, busy, flush_ack} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got %b want 0000", {inval_valid, lookup_block, busy, flush_ack});
    end
    checks++;
    if (inval_addr !== '0) begin
      errors++; $display("FAIL reset_addr got %0d want 0", inval_addr);
    end
    checks++;
    if ({valid2, block2, busy2, ack2, addr2} !== 5'b00000) begin
      errors++; $display("FAIL reset_outputs_d2 got %b want 00000", {valid2, block2, busy2, ack2, addr2});
    end
`ifdef ICACHE_FLUSH_STATS_EN
    checks++;
    if ({count1, cycles1} !== 64'd0) begin
      errors++; $display("FAIL reset_stats got %0d/%0d want 0/0", count1, cycles1);
    end
`endif
    rst = 1'b0; flush_req = 1'b0; req2 = 1'b0;
    tick;
  endtask

  task automatic test_basic_sweep;
    int acks = 0;
    int e;
    inval_ready = 1'b1; miss_inflight = 1'b0;
    push_sweep(DEPTH);
    for (int c = 0; c <= 70; c++) begin
      flush_req = (c == 0);
      checks++;
      if (inval_valid !== 1'((c >= 2) && (c <= 65))) begin
        errors++; $display("FAIL basic_valid c=%0d got %b want %b", c, inval_valid, (c >= 2) && (c <= 65));
      end
      checks++;
      if (flush_ack !== 1'(c == 66)) begin
        errors++; $display("FAIL basic_ack c=%0d got %b want %b", c, flush_ack, c == 66);
      end
      checks++;
      if ({busy, lookup_block} !== {2{1'((c >= 1) && (c <= 66))}}) begin
        errors++; $display("FAIL basic_busy c=%0d got %b want %b", c, {busy, lookup_block}, (c >= 1) && (c <= 66));
      end
      if (flush_ack) acks++;
      if (inval_valid && inval_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL basic_extra_xfer got addr %0d want none", inval_addr);
        end else begin
          e = exp_q.pop_front();
          if (inval_addr !== AW'(e)) begin
            errors++; $display("FAIL basic_addr got %0d want %0d", inval_addr, e);
          end
        end
      end
      tick;
    end
    checks++;
    if ((exp_q.size() != 0) || (acks != 1)) begin
      errors++; $display("FAIL basic_totals got left=%0d acks=%0d want left=0 acks=1", exp_q.size(), acks);
    end
    exp_q.delete();
  endtask

  task automatic test_miss_drain;
    int e;
    inval_ready = 1'b1;
    push_sweep(DEPTH);
    for (int c = 0; c <= 72; c++) begin
      flush_req     = (c == 0);
      miss_inflight = (c <= 4);
      checks++;
      if (inval_valid !== 1'((c >= 6) && (c <= 69))) begin
        errors++; $display("FAIL miss_valid c=%0d got %b want %b", c, inval_valid, (c >= 6) && (c <= 69));
      end
      checks++;
      if (lookup_block !== 1'((c >= 1) && (c <= 70))) begin
        errors++; $display("FAIL miss_block c=%0d got %b want %b", c, lookup_block, (c >= 1) && (c <= 70));
      end
      checks++;
      if (flush_ack !== 1'(c == 70)) begin
        errors++; $display("FAIL miss_ack c=%0d got %b want %b", c, flush_ack, c == 70);
      end
      if (inval_valid && inval_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL miss_extra_xfer got addr %0d want none", inval_addr);
        end else begin
          e = exp_q.pop_front();
          if (inval_addr !== AW'(e)) begin
            errors++; $display("FAIL miss_addr got %0d want %0d", inval_addr, e);
          end
        end
      end
      tick;
    end
    miss_inflight = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL miss_left got %0d want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_ready_toggle;
    int acks = 0;
    int e;
    logic prev_hold = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic done = 1'b0;
    push_sweep(DEPTH);
    for (int c = 0; (c < 400) && !done; c++) begin
      flush_req   = (c == 0);
      inval_ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (prev_hold) begin
        checks++;
        if (!inval_valid || (inval_addr !== prev_addr)) begin
          errors++; $display("FAIL toggle_hold got v=%b a=%0d want v=1 a=%0d", inval_valid, inval_addr, prev_addr);
        end
      end
      prev_hold = inval_valid && !inval_ready;
      prev_addr = inval_addr;
      if (flush_ack) acks++;
      if (acks != 0 && !busy) done = 1'b1;
      if (inval_valid && inval_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL toggle_extra_xfer got addr %0d want none", inval_addr);
        end else begin
          e = exp_q.pop_front();
          if (inval_addr !== AW'(e)) begin
            errors++; $display("FAIL toggle_addr got %0d want %0d", inval_addr, e);
          end
        end
      end
      tick;
    end
    checks++;
    if (!done || (acks != 1) || (exp_q.size() != 0)) begin
      errors++; $display("FAIL toggle_totals got done=%b acks=%0d left=%0d want done=1 acks=1 left=0", done, acks, exp_q.size());
    end
    inval_ready = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_pending;
    int acks = 0;
    int xfers = 0;
    int e;
    logic sent_sweep_req = 1'b0;
    inval_ready = 1'b1;
    push_sweep(DEPTH);
    push_sweep(DEPTH);
    for (int c = 0; c <= 140; c++) begin
      flush_req = (c <= 1);
      if (inval_valid && (inval_addr == AW'(10)) && !sent_sweep_req) begin
        flush_req = 1'b1; sent_sweep_req = 1'b1;
      end
      if (flush_ack && (acks == 0)) flush_req = 1'b1;
      checks++;
      if (flush_ack !== 1'((c == 66) || (c == 132))) begin
        errors++; $display("FAIL pend_ack c=%0d got %b want %b", c, flush_ack, (c == 66) || (c == 132));
      end
      checks++;
      if (busy !== 1'((c >= 1) && (c <= 132))) begin
        errors++; $display("FAIL pend_busy c=%0d got %b want %b", c, busy, (c >= 1) && (c <= 132));
      end
      if (flush_ack) acks++;
      if (inval_valid && inval_ready) begin
        xfers++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL pend_extra_xfer got addr %0d want none", inval_addr);
        end else begin
          e = exp_q.pop_front();
          if (inval_addr !== AW'(e)) begin
            errors++; $display("FAIL pend_addr got %0d want %0d", inval_addr, e);
          end
        end
      end
      tick;
    end
    flush_req = 1'b0;
    checks++;
    if ((xfers != 2 * DEPTH) || (acks != 2)) begin
      errors++; $display("FAIL pend_totals got xfers=%0d acks=%0d want xfers=128 acks=2", xfers, acks);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    int e;
    logic hit = 1'b0;
    inval_ready = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      flush_req = (c == 0);
      if (inval_valid && (inval_addr == AW'(30))) begin
        hit = 1'b1;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        break;
      end
      tick;
    end
    flush_req = 1'b0;
    checks++;
    if (!hit) begin
      errors++; $display("FAIL rstmid_reach got no addr 30 want addr 30 within 40 cycles");
    end
    checks++;
    if ({inval_valid, lookup_block, busy, flush_ack, inval_addr} !== '0) begin
      errors++; $display("FAIL rstmid_outputs got %b want 0", {inval_valid, lookup_block, busy, flush_ack, inval_addr});
    end
    for (int c = 0; c < 5; c++) begin
      tick;
      checks++;
      if (flush_ack || busy) begin
        errors++; $display("FAIL rstmid_quiet got ack=%b busy=%b want 0/0", flush_ack, busy);
      end
    end
    push_sweep(DEPTH);
    for (int c = 0; c <= 68; c++) begin
      flush_req = (c == 0);
      checks++;
      if (flush_ack !== 1'(c == 66)) begin
        errors++; $display("FAIL rstmid_ack c=%0d got %b want %b", c, flush_ack, c == 66);
      end
      if (inval_valid && inval_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rstmid_extra_xfer got addr %0d want none", inval_addr);
        end else begin
          e = exp_q.pop_front();
          if (inval_addr !== AW'(e)) begin
            errors++; $display("FAIL rstmid_addr got %0d want %0d", inval_addr, e);
          end
        end
      end
      tick;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rstmid_left got %0d want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_depth2;
    int e;
    int busy_total = 0;
    int acks = 0;
    ready2 = 1'b1;
    for (int s = 0; s < 3; s++) begin
      push_sweep(DEPTH2);
      for (int c = 0; c <= 6; c++) begin
        req2 = (c == 0);
        checks++;
        if (valid2 !== 1'((c == 2) || (c == 3))) begin
          errors++; $display("FAIL d2_valid s=%0d c=%0d got %b want %b", s, c, valid2, (c == 2) || (c == 3));
        end
        checks++;
        if (ack2 !== 1'(c == 4)) begin
          errors++; $display("FAIL d2_ack s=%0d c=%0d got %b want %b", s, c, ack2, c == 4);
        end
        if (busy2) busy_total++;
        if (ack2) acks++;
        if (valid2 && ready2) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL d2_extra_xfer got addr %0d want none", addr2);
          end else begin
            e = exp_q.pop_front();
            if (addr2 !== AW2'(e)) begin
              errors++; $display("FAIL d2_addr got %0d want %0d", addr2, e);
            end
          end
        end
        tick;
      end
    end
    req2 = 1'b0;
    checks++;
    if ((exp_q.size() != 0) || (acks != 3) || (busy_total != 12)) begin
      errors++; $display("FAIL d2_totals got left=%0d acks=%0d busy=%0d want 0/3/12", exp_q.size(), acks, busy_total);
    end
`ifdef ICACHE_FLUSH_STATS_EN
    checks++;
    if (count2 !== 32'd3) begin
      errors++; $display("FAIL d2_flush_count got %0d want 3", count2);
    end
    checks++;
    if (cycles2 !== 32'd12) begin
      errors++; $display("FAIL d2_flush_cycles got %0d want 12", cycles2);
    end
`endif
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush_req = 1'b0; miss_inflight = 1'b0; inval_ready = 1'b1;
    req2 = 1'b0; miss2 = 1'b0; ready2 = 1'b1;
    #1;
    test_reset;
    test_basic_sweep;
    test_miss_drain;
    test_ready_toggle;
    test_pending;
    test_reset_mid;
    test_depth2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
